// File: rtl/app_mult_sched.sv
// ---------------------------------------------------------------------------
// app_mult_sched
// Round-robin scheduler that time-shares one external combinational
// approximate multiplier between NREQ requesters. One operand pair is
// granted per IDLE cycle. The winner's operands are registered onto
// mult_a/mult_b, and the product is captured one cycle later. The result is
// returned with the requester index over a valid/ready handshake.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   req_valid  : per-requester request valid
//   req_ready  : per-requester grant (one-hot or zero, combinational)
//   req_a      : packed operand A, requester i at [i*WIDTH1 +: WIDTH1]
//   req_b      : packed operand B, requester i at [i*WIDTH2 +: WIDTH2]
//   mult_a     : registered operand A to the shared multiplier
//   mult_b     : registered operand B to the shared multiplier
//   mult_cin   : multiplier carry-in, always 0
//   mult_sum   : product returned by the shared multiplier
//   rsp_valid  : response valid
//   rsp_ready  : response consumer ready
//   rsp_sum    : registered product
//   rsp_id     : requester index of the response
//   busy       : high whenever the FSM is not in IDLE
//   ops_done   : completed-response counter, wraps 0xFFFF -> 0
// ---------------------------------------------------------------------------
module app_mult_sched #(
    parameter  int unsigned WIDTH1 = 8,
    parameter  int unsigned WIDTH2 = 8,
    parameter  int unsigned NREQ   = 4,
    localparam int unsigned IDW    = $clog2(NREQ),
    localparam int unsigned PW     = WIDTH1 + WIDTH2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH1-1:0]   req_a,
    input  logic [NREQ*WIDTH2-1:0]   req_b,
    output logic [WIDTH1-1:0]        mult_a,
    output logic [WIDTH2-1:0]        mult_b,
    output logic                     mult_cin,
    input  logic [PW-1:0]            mult_sum,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [PW-1:0]            rsp_sum,
    output logic [IDW-1:0]           rsp_id,
    output logic                     busy,
    output logic [15:0]              ops_done
);

    localparam int unsigned CNTW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    state_e              state_q;
    logic [IDW-1:0]      rr_ptr_q;
    logic [IDW-1:0]      id_q;
    logic [WIDTH1-1:0]   mult_a_q;
    logic [WIDTH2-1:0]   mult_b_q;
    logic                rsp_valid_q;
    logic [PW-1:0]       rsp_sum_q;
    logic [IDW-1:0]      rsp_id_q;
    logic [CNTW-1:0]     ops_done_q;

    logic                grant_found;
    logic [IDW-1:0]      grant_idx;
    logic [IDW-1:0]      cand_idx;
    logic                grant_ok;
    logic [WIDTH1-1:0]   sel_a;
    logic [WIDTH2-1:0]   sel_b;

    // Round-robin search: start just after the last winner and wrap,
    // so the most recently served requester has the lowest priority.
    always_comb begin : rr_arbiter
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand_idx = IDW'((32'(rr_ptr_q) + off) % NREQ);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // A grant is only offered from IDLE and never while reset is asserted.
    assign grant_ok  = (state_q == ST_IDLE) && !rst && grant_found;
    assign req_ready = grant_ok ? (NREQ'(1) << grant_idx) : '0;

    // Operand mux for the current winner.
    assign sel_a = req_a[32'(grant_idx) * WIDTH1 +: WIDTH1];
    assign sel_b = req_b[32'(grant_idx) * WIDTH2 +: WIDTH2];

    // Scheduler FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            id_q        <= '0;
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            ops_done_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (grant_found) begin
                        mult_a_q <= sel_a;
                        mult_b_q <= sel_b;
                        id_q     <= grant_idx;
                        rr_ptr_q <= grant_idx;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Operands were stable for a full cycle; product has settled.
                    rsp_sum_q   <= mult_sum;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_valid_q && rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ops_done_q  <= ops_done_q + CNTW'(1);
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mult_a    = mult_a_q;
    assign mult_b    = mult_b_q;
    assign mult_cin  = 1'b0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != ST_IDLE);
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_app_mult_sched.sv
// ---------------------------------------------------------------------------
// tb_app_mult_sched
// Self-checking bench for app_mult_sched with an exact multiplier stub.
// Requester operands come from per-requester op lists. The expected
// {id, product} is pushed when a grant is seen and popped when the
// response handshake occurs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_app_mult_sched;

    localparam int unsigned W1    = 8;
    localparam int unsigned W2    = 8;
    localparam int unsigned NR    = 4;
    localparam int unsigned IDW   = 2;
    localparam int unsigned PW    = 16;
    localparam int unsigned DEPTH = 64;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [PW-1:0]  sum;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*W1-1:0]  req_a;
    logic [NR*W2-1:0]  req_b;
    logic [W1-1:0]     mult_a;
    logic [W2-1:0]     mult_b;
    logic              mult_cin;
    logic [PW-1:0]     mult_sum;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [PW-1:0]     rsp_sum;
    logic [IDW-1:0]    rsp_id;
    logic              busy;
    logic [15:0]       ops_done;

    int                tests_run;
    int                tests_failed;

    exp_t              sb[$];
    exp_t              mon_e;
    int                grant_log[$];
    int                grant_cyc[$];
    logic [15:0]       exp_ops;

    logic [W1-1:0]     opa [NR][DEPTH];
    logic [W2-1:0]     opb [NR][DEPTH];
    int                head [NR];
    int                tail [NR];
    int                cyc;
    logic [NR-1:0]     gnt_seen;

    app_mult_sched #(
        .WIDTH1 (W1),
        .WIDTH2 (W2),
        .NREQ   (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_cin  (mult_cin),
        .mult_sum  (mult_sum),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    // Exact multiplier stub standing in for the shared approximate unit.
    assign mult_sum = PW'(mult_a) * PW'(mult_b);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic enq(input int r, input logic [W1-1:0] a, input logic [W2-1:0] b);
        opa[r][tail[r]] = a;
        opb[r][tail[r]] = b;
        tail[r]++;
    endtask

    function automatic bit pending_none();
        bit none;
        none = 1'b1;
        for (int i = 0; i < NR; i++)
            if (head[i] != tail[i]) none = 1'b0;
        return none;
    endfunction

    // Requester model and scoreboard monitor.
    initial begin
        cyc = 0;
        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        forever begin
            @(negedge clk);
            cyc++;
            gnt_seen = rst ? '0 : req_ready;
            if (!rst && req_ready != '0) begin
                tests_run++;
                if (!$onehot(req_ready)) begin
                    tests_failed++;
                    $display("FAIL grant_onehot: req_ready=%b, required one-hot", req_ready);
                end
                for (int i = 0; i < NR; i++) begin
                    if (req_ready[i]) begin
                        mon_e.id  = IDW'(i);
                        mon_e.sum = PW'(opa[i][head[i]]) * PW'(opb[i][head[i]]);
                        sb.push_back(mon_e);
                        grant_log.push_back(i);
                        grant_cyc.push_back(cyc);
                    end
                end
            end
            if (!rst && rsp_valid && rsp_ready) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rsp_unexpected: got id=%0d sum=%0d, required no response", rsp_id, rsp_sum);
                end else begin
                    mon_e = sb.pop_front();
                    if (rsp_id !== mon_e.id || rsp_sum !== mon_e.sum) begin
                        tests_failed++;
                        $display("FAIL rsp_data: got id=%0d sum=%0d, required id=%0d sum=%0d",
                                 rsp_id, rsp_sum, mon_e.id, mon_e.sum);
                    end
                end
                tests_run++;
                if (ops_done !== exp_ops) begin
                    tests_failed++;
                    $display("FAIL ops_done_count: got %h, required %h", ops_done, exp_ops);
                end
                exp_ops = exp_ops + 16'd1;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (gnt_seen[i]) head[i]++;
                if (head[i] < tail[i]) begin
                    req_valid[i]           = 1'b1;
                    req_a[i*W1 +: W1]      = opa[i][head[i]];
                    req_b[i*W2 +: W2]      = opb[i][head[i]];
                end else begin
                    req_valid[i]           = 1'b0;
                    req_a[i*W1 +: W1]      = W1'($urandom);
                    req_b[i*W2 +: W2]      = W2'($urandom);
                end
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        grant_log.delete();
        grant_cyc.delete();
        exp_ops = 16'd0;
        rst     = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && pending_none() && !busy && !rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        repeat (2) @(posedge clk);
        #1;
        enq(1, 8'd17, 8'd3);
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (req_valid !== 4'b0010 || req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_no_grant: req_valid=%b req_ready=%b, required req_ready=0000", req_valid, req_ready);
        end
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 16'd0 || rsp_id !== 2'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rsp: valid=%b sum=%0d id=%0d busy=%b, required all 0", rsp_valid, rsp_sum, rsp_id, busy);
        end
        tests_run++;
        if (mult_a !== 8'd0 || mult_b !== 8'd0 || mult_cin !== 1'b0 || ops_done !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_mult: a=%0d b=%0d cin=%b ops=%0d, required all 0", mult_a, mult_b, mult_cin, ops_done);
        end
        @(posedge clk);
        #1;
        sb.delete();
        exp_ops   = 16'd0;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL reset_release_grant: req_ready=%b, required 0010", req_ready);
        end
        wait_idle(ok);
        tests_run++;
        if (!ok || ops_done !== 16'd1) begin
            tests_failed++;
            $display("FAIL reset_first_op: idle=%b ops_done=%0d, required idle=1 ops_done=1", ok, ops_done);
        end
    endtask

    task automatic test_single();
        bit ok;
        apply_reset();
        rsp_ready = 1'b1;
        enq(2, 8'd200, 8'd150);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!ok || req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL single_grant: req_ready=%b, required 0100", req_ready);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (mult_a !== 8'd200 || mult_b !== 8'd150 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_issue: a=%0d b=%0d rsp_valid=%b busy=%b, required 200 150 0 1", mult_a, mult_b, rsp_valid, busy);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 16'd30000 || rsp_id !== 2'd2) begin
            tests_failed++;
            $display("FAIL single_rsp: valid=%b sum=%0d id=%0d, required 1 30000 2", rsp_valid, rsp_sum, rsp_id);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || ops_done !== 16'd1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: valid=%b ops=%0d busy=%b, required 0 1 0", rsp_valid, ops_done, busy);
        end
        wait_idle(ok);
    endtask

    task automatic test_all_four();
        bit ok;
        bit bad;
        int exp_order [8];
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        apply_reset();
        rsp_ready = 1'b1;
        for (int rep = 0; rep < 2; rep++)
            for (int r = 0; r < NR; r++)
                enq(r, W1'($urandom_range(0, 255)), W2'($urandom_range(0, 255)));
        wait_idle(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL all_four_timeout: still busy, required drained");
        end
        bad = (grant_log.size() != 8);
        if (!bad)
            for (int i = 0; i < 8; i++)
                if (grant_log[i] != exp_order[i]) bad = 1'b1;
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL all_four_order: got %p, required 0,1,2,3,0,1,2,3", grant_log);
        end
        bad = (grant_cyc.size() != 8);
        if (!bad)
            for (int i = 1; i < 8; i++)
                if (grant_cyc[i] - grant_cyc[i-1] != 3) bad = 1'b1;
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL throughput: grant cycles %p, required spacing 3", grant_cyc);
        end
    endtask

    task automatic test_fairness();
        bit ok;
        bit bad;
        int exp_order [6];
        exp_order = '{1, 3, 1, 3, 1, 3};
        apply_reset();
        rsp_ready = 1'b1;
        for (int rep = 0; rep < 3; rep++) begin
            enq(1, W1'(rep + 10), W2'(rep + 20));
            enq(3, W1'(rep + 100), W2'(rep + 200));
        end
        wait_idle(ok);
        bad = !ok || (grant_log.size() != 6);
        if (!bad)
            for (int i = 0; i < 6; i++)
                if (grant_log[i] != exp_order[i]) bad = 1'b1;
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL fairness_order: idle=%b got %p, required 1,3,1,3,1,3", ok, grant_log);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit bad;
        apply_reset();
        rsp_ready = 1'b0;
        enq(0, 8'd255, 8'd255);
        enq(1, 8'd3, 8'd7);
        enq(2, 8'd10, 8'd20);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL bp_rsp_timeout: rsp_valid=%b, required 1", rsp_valid);
        end
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_sum !== 16'd65025 || rsp_id !== 2'd0 ||
                req_ready !== 4'b0000 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_hold: cyc=%0d valid=%b sum=%0d id=%0d req_ready=%b busy=%b, required 1 65025 0 0000 1",
                         k, rsp_valid, rsp_sum, rsp_id, req_ready, busy);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 16'd1) begin
            tests_failed++;
            $display("FAIL bp_release: valid=%b busy=%b ops=%0d, required 0 0 1", rsp_valid, busy, ops_done);
        end
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL bp_next_grant: req_ready=%b, required 0010", req_ready);
        end
        wait_idle(ok);
        bad = !ok || grant_log.size() != 3;
        if (!bad) bad = (grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 2);
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL bp_order: idle=%b got %p, required 0,1,2", ok, grant_log);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        // Reset while in ISSUE.
        apply_reset();
        rsp_ready = 1'b1;
        enq(1, 8'd9, 8'd9);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (!ok || busy !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_issue_setup: granted=%b busy=%b valid=%b, required 1 1 0", ok, busy, rsp_valid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || mult_a !== 8'd0 || mult_b !== 8'd0 || ops_done !== 16'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_issue_reset: valid=%b a=%0d b=%0d ops=%0d busy=%b, required all 0",
                     rsp_valid, mult_a, mult_b, ops_done, busy);
        end
        sb.delete();
        grant_log.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Reset while in RESP with the response pending.
        rsp_ready = 1'b0;
        enq(2, 8'd11, 8'd13);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (!ok || rsp_valid !== 1'b0 || mult_a !== 8'd0 || mult_b !== 8'd0 || ops_done !== 16'd0) begin
            tests_failed++;
            $display("FAIL mid_resp_reset: reached=%b valid=%b a=%0d b=%0d ops=%0d, required 1 0 0 0 0",
                     ok, rsp_valid, mult_a, mult_b, ops_done);
        end
        sb.delete();
        grant_log.delete();
        exp_ops = 16'd0;
        enq(3, 8'd21, 8'd2);
        enq(0, 8'd40, 8'd5);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!ok || req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL mid_first_grant: req_ready=%b, required 0001", req_ready);
        end
        wait_idle(ok);
        tests_run++;
        if (!ok || ops_done !== 16'd2) begin
            tests_failed++;
            $display("FAIL mid_drain: idle=%b ops=%0d, required 1 2", ok, ops_done);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        apply_reset();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        force dut.ops_done_q = 16'hFFFE;
        #1;
        release dut.ops_done_q;
        exp_ops = 16'hFFFE;
        @(negedge clk);
        tests_run++;
        if (ops_done !== 16'hFFFE) begin
            tests_failed++;
            $display("FAIL wrap_preload: ops_done=%h, required fffe", ops_done);
        end
        enq(1, 8'd5, 8'd6);
        enq(1, 8'd7, 8'd8);
        enq(1, 8'd250, 8'd251);
        wait_idle(ok);
        tests_run++;
        if (!ok || ops_done !== 16'h0001 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_final: idle=%b ops=%h busy=%b valid=%b, required 1 0001 0 0",
                     ok, ops_done, busy, rsp_valid);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_ops      = 16'd0;
        rst          = 1'b1;
        rsp_ready    = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
